// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, butterfly mode encoding and modular add/sub helpers.
package dilithium_pkg;

    localparam int unsigned Q       = 8380417;
    localparam int unsigned COEFF_W = 23;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned LAT     = 4;
    localparam int unsigned PROD_W  = 2 * COEFF_W;
    // 2^23 mod Q = 2^13 - 1, used to fold the high part of a product.
    localparam int unsigned FOLD_C  = 8191;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bf_mode_e;

    // Per-beat control that travels alongside the datapath.
    typedef struct packed {
        logic              valid;
        bf_mode_e          mode;
        logic              last;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
    } bf_meta_t;

    // (a + b) mod Q for canonical operands: one conditional subtract.
    function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [COEFF_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (COEFF_W+1)'(Q)) begin
            s = s - (COEFF_W+1)'(Q);
        end
        return COEFF_W'(s);
    endfunction

    // (a - b) mod Q for canonical operands: one conditional add; wrap in COEFF_W bits is exact.
    function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] a,
                                                   input logic [COEFF_W-1:0] b);
        logic [COEFF_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + COEFF_W'(Q) - b;
        end
        return d;
    endfunction

endpackage

// File: rtl/butterfly_unit_mod_mul_q.sv
// Modular multiplier mod Q: registered product, then one-cycle reduction (2-cycle latency).
module mod_mul_q
    import dilithium_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [COEFF_W-1:0] x_i,
    input  logic [COEFF_W-1:0] y_i,
    output logic [COEFF_W-1:0] z_o
);

    logic [PROD_W-1:0]  prod_q;
    logic [COEFF_W-1:0] z_q;
    logic [COEFF_W-1:0] z_d;

    // Exact reduction of p < Q^2 by repeated folding with 2^23 = 2^13 - 1 (mod Q).
    function automatic logic [COEFF_W-1:0] reduce_q(input logic [PROD_W-1:0] p);
        logic [36:0] x1;
        logic [27:0] x2;
        logic [23:0] x3;
        x1 = 37'(p[45:23]) * 37'(FOLD_C) + 37'(p[22:0]);
        x2 = 28'(x1[36:23]) * 28'(FOLD_C) + 28'(x1[22:0]);
        x3 = 24'(x2[27:23]) * 24'(FOLD_C) + 24'(x2[22:0]);
        if (x3 >= 24'(Q)) begin
            x3 = x3 - 24'(Q);
        end
        return COEFF_W'(x3);
    endfunction

    // Reduction of the registered product.
    always_comb begin
        z_d = reduce_q(prod_q);
    end

    // Product and reduced-result registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            z_q    <= '0;
        end else begin
            prod_q <= PROD_W'(x_i) * PROD_W'(y_i);
            z_q    <= z_d;
        end
    end

    assign z_o = z_q;

endmodule

// File: rtl/butterfly_unit.sv
// Four-stage radix-2 NTT/INTT butterfly with in-place write-back addressing.
module butterfly_unit
    import dilithium_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               mode_i,
    input  logic               last_i,
    input  logic [COEFF_W-1:0] a_i,
    input  logic [COEFF_W-1:0] b_i,
    input  logic [COEFF_W-1:0] w_i,
    input  logic [ADDR_W-1:0]  addr1_i,
    input  logic [ADDR_W-1:0]  addr2_i,
    output logic               valid_o,
    output logic               wren_o,
    output logic               last_o,
    output logic [COEFF_W-1:0] a_o,
    output logic [COEFF_W-1:0] b_o,
    output logic [ADDR_W-1:0]  addr1_o,
    output logic [ADDR_W-1:0]  addr2_o,
    output logic               busy_o
);

    bf_meta_t           meta_in_c;
    bf_meta_t           m1_q, m2_q, m3_q;
    logic [COEFF_W-1:0] a1_q, b1_q, w1_q, sum1_q, diff1_q;
    logic [COEFF_W-1:0] a2_q, sum2_q, a3_q, sum3_q;
    logic [COEFF_W-1:0] mul_op_c, t3_c;

    logic               valid_q, wren_q, last_q, busy_q;
    logic               valid_d, last_d, busy_d;
    logic [COEFF_W-1:0] a_q, b_q, a_d, b_d;
    logic [ADDR_W-1:0]  addr1_q, addr2_q;

    // Bundle per-beat control for transport down the pipe.
    always_comb begin
        meta_in_c       = '0;
        meta_in_c.valid = valid_i;
        meta_in_c.mode  = bf_mode_e'(mode_i);
        meta_in_c.last  = last_i;
        meta_in_c.addr1 = addr1_i;
        meta_in_c.addr2 = addr2_i;
    end

    // S1: capture the beat and precompute the GS sum/difference.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m1_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            w1_q    <= '0;
            sum1_q  <= '0;
            diff1_q <= '0;
        end else begin
            m1_q    <= meta_in_c;
            a1_q    <= a_i;
            b1_q    <= b_i;
            w1_q    <= w_i;
            sum1_q  <= mod_add(a_i, b_i);
            diff1_q <= mod_sub(a_i, b_i);
        end
    end

    // Multiplier operand: b for CT, (a - b) for GS.
    always_comb begin
        mul_op_c = (m1_q.mode == BF_GS) ? diff1_q : b1_q;
    end

    mod_mul_q u_mul (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .x_i   (mul_op_c),
        .y_i   (w1_q),
        .z_o   (t3_c)
    );

    // S2/S3: carry control, a and the GS sum alongside the multiplier.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m2_q   <= '0;
            a2_q   <= '0;
            sum2_q <= '0;
            m3_q   <= '0;
            a3_q   <= '0;
            sum3_q <= '0;
        end else begin
            m2_q   <= m1_q;
            a2_q   <= a1_q;
            sum2_q <= sum1_q;
            m3_q   <= m2_q;
            a3_q   <= a2_q;
            sum3_q <= sum2_q;
        end
    end

    // S4 next values: CT post-add/sub or GS pass-through; busy covers every occupied stage.
    always_comb begin
        valid_d = m3_q.valid;
        last_d  = m3_q.valid & m3_q.last;
        busy_d  = valid_i | m1_q.valid | m2_q.valid | m3_q.valid;
        a_d     = mod_add(a3_q, t3_c);
        b_d     = mod_sub(a3_q, t3_c);
        if (m3_q.mode == BF_GS) begin
            a_d = sum3_q;
            b_d = t3_c;
        end
    end

    // S4: output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            wren_q  <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            valid_q <= valid_d;
            wren_q  <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr1_q <= m3_q.addr1;
            addr2_q <= m3_q.addr2;
        end
    end

    assign valid_o = valid_q;
    assign wren_o  = wren_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign addr1_o = addr1_q;
    assign addr2_o = addr2_q;

endmodule

// File: tb/tb_butterfly_unit.sv
// Randomised and directed checks of butterfly_unit against an arithmetic reference model.
module tb_butterfly_unit;

    localparam longint unsigned QM = 64'd8380417;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, mode_i, last_i;
    logic [22:0] a_i, b_i, w_i;
    logic [7:0]  addr1_i, addr2_i;
    logic        valid_o, wren_o, last_o, busy_o;
    logic [22:0] a_o, b_o;
    logic [7:0]  addr1_o, addr2_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic        last;
        logic [22:0] a;
        logic [22:0] b;
        logic [7:0]  ad1;
        logic [7:0]  ad2;
    } exp_t;

    exp_t exp_q[int];

    butterfly_unit dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .mode_i  (mode_i),
        .last_i  (last_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .w_i     (w_i),
        .addr1_i (addr1_i),
        .addr2_i (addr2_i),
        .valid_o (valid_o),
        .wren_o  (wren_o),
        .last_o  (last_o),
        .a_o     (a_o),
        .b_o     (b_o),
        .addr1_o (addr1_o),
        .addr2_o (addr2_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input longint unsigned got, input longint unsigned want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, want);
        end
    endtask

    function automatic logic [45:0] ref_bf(input logic mode, input longint unsigned a,
                                           input longint unsigned b, input longint unsigned w);
        longint unsigned t, ra, rb;
        if (mode == 1'b0) begin
            t  = (w * b) % QM;
            ra = (a + t) % QM;
            rb = (a + QM - t) % QM;
        end else begin
            ra = (a + b) % QM;
            rb = (((a + QM - b) % QM) * w) % QM;
        end
        return {23'(ra), 23'(rb)};
    endfunction

    // Compare outputs against what the model expects for the current cycle.
    task automatic check_outputs();
        logic busy_exp;
        busy_exp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (exp_q.exists(cyc + k)) busy_exp = 1'b1;
        end
        check_val("busy", 64'(busy_o), 64'(busy_exp));
        if (exp_q.exists(cyc)) begin
            check_val("valid", 64'(valid_o), 64'd1);
            check_val("wren", 64'(wren_o), 64'd1);
            check_val("last", 64'(last_o), 64'(exp_q[cyc].last));
            check_val("a_o", 64'(a_o), 64'(exp_q[cyc].a));
            check_val("b_o", 64'(b_o), 64'(exp_q[cyc].b));
            check_val("addr1", 64'(addr1_o), 64'(exp_q[cyc].ad1));
            check_val("addr2", 64'(addr2_o), 64'(exp_q[cyc].ad2));
            exp_q.delete(cyc);
        end else begin
            check_val("idle_valid", 64'(valid_o), 64'd0);
            check_val("idle_wren", 64'(wren_o), 64'd0);
            check_val("idle_last", 64'(last_o), 64'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic drive_beat(input logic mode, input logic last, input logic [22:0] a,
                              input logic [22:0] b, input logic [22:0] w,
                              input logic [7:0] ad1, input logic [7:0] ad2);
        logic [45:0] r;
        exp_t e;
        valid_i = 1'b1; mode_i = mode; last_i = last;
        a_i = a; b_i = b; w_i = w; addr1_i = ad1; addr2_i = ad2;
        r = ref_bf(mode, 64'(a), 64'(b), 64'(w));
        e.last = last; e.a = r[45:23]; e.b = r[22:0]; e.ad1 = ad1; e.ad2 = ad2;
        exp_q[cyc + 4] = e;
    endtask

    task automatic drive_idle();
        valid_i = 1'b0; mode_i = 1'($urandom); last_i = 1'($urandom);
        a_i = 23'($urandom % 32'(QM)); b_i = 23'($urandom % 32'(QM)); w_i = 23'($urandom % 32'(QM));
        addr1_i = 8'($urandom); addr2_i = 8'($urandom);
    endtask

    task automatic drive_rand(input logic mode, input logic last);
        drive_beat(mode, last, 23'($urandom % 32'(QM)), 23'($urandom % 32'(QM)),
                   23'($urandom % 32'(QM)), 8'($urandom), 8'($urandom));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        #2;
        check_val("rst_valid", 64'(valid_o), 64'd0);
        check_val("rst_wren", 64'(wren_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_a", 64'(a_o), 64'd0);
        check_val("rst_b", 64'(b_o), 64'd0);
        check_val("rst_addr1", 64'(addr1_o), 64'd0);
        check_val("rst_addr2", 64'(addr2_o), 64'd0);
        idle_cycles(2);
        rst_i = 1'b0;

        // Directed vectors.
        drive_beat(1'b0, 1'b0, 23'd1, 23'd1, 23'd1, 8'd10, 8'd11);
        tick(); idle_cycles(5);
        drive_beat(1'b0, 1'b0, 23'd0, 23'(QM - 1), 23'(QM - 1), 8'd20, 8'd21);
        tick(); idle_cycles(5);
        drive_beat(1'b1, 1'b0, 23'd5, 23'd3, 23'd2, 8'd30, 8'd31);
        tick();
        drive_beat(1'b1, 1'b1, 23'd0, 23'd1, 23'd1, 8'd40, 8'd41);
        tick(); idle_cycles(6);

        // 128 back-to-back beats, alternating modes, last on the final one.
        for (int i = 0; i < 128; i++) begin
            drive_rand(1'(i % 2), (i == 127));
            tick();
        end
        idle_cycles(6);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'(i % 2), 1'b1);
            tick();
        end
        drive_idle();
        #2 rst_i = 1'b1;
        #1;
        check_val("midrst_valid", 64'(valid_o), 64'd0);
        check_val("midrst_wren", 64'(wren_o), 64'd0);
        check_val("midrst_last", 64'(last_o), 64'd0);
        check_val("midrst_busy", 64'(busy_o), 64'd0);
        check_val("midrst_a", 64'(a_o), 64'd0);
        check_val("midrst_b", 64'(b_o), 64'd0);
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        drive_rand(1'b0, 1'b1);
        tick(); idle_cycles(6);

        // Sparse traffic: one beat every third cycle.
        for (int i = 0; i < 20; i++) begin
            drive_rand(1'($urandom), 1'(i == 19));
            tick();
            idle_cycles(2);
        end
        idle_cycles(6);

        check_val("drained", 64'(exp_q.num()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly_unit.md
# butterfly_unit

Pipelined radix-2 butterfly for the Dilithium NTT/INTT datapath, sitting directly downstream of the address generator. Each cycle it accepts one coefficient pair with its twiddle, read addresses and mode, and returns the reduced result pair after a fixed 4-cycle latency. Results carry their write-back addresses and a write enable, so the coefficient RAM is written in place. Throughput is one butterfly per cycle with no backpressure.

## Interface
- Q, 8380417, Dilithium modulus.
- COEFF_W, 23, coefficient width.
- ADDR_W, 8, coefficient RAM address width.
- LAT, 4, input-to-output latency in cycles; fixed, not user-tunable.

- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  input beat valid
- mode_i  in  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande)
- last_i  in  1  marks final beat of a layer
- a_i, b_i  in  COEFF_W  coefficients, must be in [0, Q)
- w_i  in  COEFF_W  twiddle, must be in [0, Q)
- addr1_i, addr2_i  in  ADDR_W  source addresses of a_i / b_i
- valid_o  out  1  output beat valid
- wren_o  out  1  RAM write enable, equals valid_o
- last_o  out  1  last_i delayed by LAT, qualified by valid
- a_o, b_o  out  COEFF_W  results, always in [0, Q)
- addr1_o, addr2_o  out  ADDR_W  write addresses for a_o / b_o
- busy_o  out  1  any pipeline stage holds a valid beat

## Operation
- NTT: t = w·b mod Q; a_o = (a + t) mod Q; b_o = (a − t) mod Q.
- INTT: a_o = (a + b) mod Q; b_o = ((a − b) mod Q)·w mod Q. n⁻¹ scaling is not performed here.
- Stages: S1 registers inputs and computes GS pre-add/sub; S2 selects multiplier operand (CT: b, GS: a−b) and multiplies by w (46-bit product); S3 reduces product mod Q; S4 performs CT post-add/sub or passes GS results, drives outputs.
- Modular add/sub: single conditional correction (subtract Q if sum ≥ Q; add Q if difference negative). Reduction must be exact for every product < Q²; method is free but must use the 2²³ ≡ 2¹³ − 1 (mod Q) identity or Barrett, fixed 1 cycle.
- mode, last, addresses and valid travel in the pipeline with each beat; mode may change on any beat without bubbles.
- Beats with valid_i = 0 produce valid_o = 0; data outputs of invalid slots are don't-care but must not toggle wren_o.
- No stall input; the consumer must accept every valid_o beat.

## Timing
- Beat accepted at edge k appears on outputs after edge k+4 (valid_o high in cycle k+4).
- Back-to-back beats produce back-to-back outputs in order.
- busy_o high from the cycle after the first accepted beat until valid_o of the last in-flight beat has been presented.
- Reset (asynchronous assert): all stage valids, valid_o, wren_o, last_o, busy_o = 0; a_o, b_o, addr1_o, addr2_o = 0. In-flight beats are discarded; no partial write occurs after reset.
- Deassertion of rst_i must be synchronised externally; the first beat may be accepted on the first edge after deassertion.

## Structure
- dilithium_pkg: Q, COEFF_W, ADDR_W, bf_mode_e {BF_CT, BF_GS}, mod_add/mod_sub functions.
- Sub-module mod_mul_q: registered multiply + 1-cycle reduction (2-cycle latency), reused later by the pointwise multiplier.

## Test plan
- NTT a=1, b=1, w=1 → a_o=2, b_o=0 after 4 cycles, wren_o pulse of 1 cycle, addresses echoed.
- NTT a=0, b=Q−1, w=Q−1 (product ≡ 1) → a_o=1, b_o=Q−1.
- INTT a=5, b=3, w=2 → a_o=8, b_o=4; INTT a=0, b=1, w=1 → a_o=1, b_o=Q−1.
- 128 consecutive beats, alternating modes, random canonical operands vs. golden model → 128 consecutive valid_o, exact match, last_o only on beat 128, busy_o drops 4 cycles after final input.
- Assert rst_i mid-stream with 3 beats in flight → all outputs 0 immediately, no valid_o/wren_o for discarded beats, new beat after release completes normally.
- Sparse input (valid every 3rd cycle) → outputs spaced identically, wren_o never high on gaps.
